btn_gesture_decoder: RTL and testbench

- Sits directly downstream of the button debouncer; consumes its debounced level output and classifies each button interaction as a single click, a double click or a long press.
- Emits one-cycle event ticks for the game/menu control FSMs, plus a level that stays high while a long press is held.
- One timer counter is shared between long-press timing and the double-click window.

---
 rtl/btn_gesture_decoder.sv | 108 ++++++++++
 tb/tb_btn_gesture_decoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_gesture_decoder.sv
// Button gesture classifier: turns a debounced button level into single-click,
// double-click and long-press events using one shared timer.
module btn_gesture_decoder #(
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned DCLICK_CYC = 25_000_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic db_level,
  output logic single_tick,
  output logic double_tick,
  output logic long_tick,
  output logic long_hold,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_LONG_HELD = 3'd2,
    S_GAP       = 3'd3,
    S_PRESS2    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] timer;

  // Ticks default low every cycle; busy and long_hold track the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      single_tick <= 1'b0;
      double_tick <= 1'b0;
      long_tick   <= 1'b0;
      long_hold   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      single_tick <= 1'b0;
      double_tick <= 1'b0;
      long_tick   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (db_level) begin
            state <= S_PRESS1;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        S_PRESS1: begin
          // A release wins over the long-press limit on the same cycle.
          if (!db_level) begin
            state <= S_GAP;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state     <= S_LONG_HELD;
            timer     <= '0;
            long_tick <= 1'b1;
            long_hold <= 1'b1;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        S_LONG_HELD: begin
          if (!db_level) begin
            state     <= S_IDLE;
            timer     <= '0;
            long_hold <= 1'b0;
            busy      <= 1'b0;
          end
        end
        S_GAP: begin
          // A press wins over window expiry on the same cycle.
          if (db_level) begin
            state       <= S_PRESS2;
            timer       <= '0;
            double_tick <= 1'b1;
          end else if (timer == DCLICK_LAST) begin
            state       <= S_IDLE;
            timer       <= '0;
            single_tick <= 1'b1;
            busy        <= 1'b0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        S_PRESS2: begin
          if (!db_level) begin
            state <= S_IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          timer     <= '0;
          long_hold <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Bench for btn_gesture_decoder: scripted gesture scenarios plus randomized
// press/release runs checked against a duration-based reference model.
module tb_btn_gesture_decoder;

  localparam int LONG_CYC   = 20;
  localparam int DCLICK_CYC = 10;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic db_level = 1'b0;
  logic single_tick, double_tick, long_tick, long_hold, busy;

  int tests = 0;
  int failed = 0;

  btn_gesture_decoder #(
    .LONG_CYC  (LONG_CYC),
    .DCLICK_CYC(DCLICK_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .db_level   (db_level),
    .single_tick(single_tick),
    .double_tick(double_tick),
    .long_tick  (long_tick),
    .long_hold  (long_hold),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Cycle index and tick recorder used by the scripted scenarios.
  int cyc = 0;
  int n_single = 0, n_double = 0, n_long = 0;
  int t_single = -1, t_double = -1, t_long = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (single_tick) begin n_single <= n_single + 1; t_single <= cyc; end
    if (double_tick) begin n_double <= n_double + 1; t_double <= cyc; end
    if (long_tick)   begin n_long   <= n_long + 1;   t_long   <= cyc; end
  end

  // Reference model: an interaction is described by how many presses it has
  // seen, whether the first press was released, and the length of the
  // current high/low run (counting the sample that started the run).
  bit m_active = 0, m_released = 0, m_long = 0;
  int m_press = 0, m_run = 0;
  bit e_single = 0, e_double = 0, e_long = 0, e_hold = 0, e_busy = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 0; m_released <= 0; m_long <= 0; m_press <= 0; m_run <= 0;
      e_single <= 0; e_double <= 0; e_long <= 0; e_hold <= 0; e_busy <= 0;
    end else begin
      e_single <= 0; e_double <= 0; e_long <= 0;
      if (!m_active) begin
        if (db_level) begin
          m_active <= 1; m_press <= 1; m_released <= 0; m_long <= 0; m_run <= 1;
          e_busy <= 1;
        end
      end else if (m_long || m_press == 2) begin
        if (!db_level) begin
          m_active <= 0; e_busy <= 0; e_hold <= 0;
        end
      end else if (!m_released) begin
        if (!db_level) begin
          m_released <= 1; m_run <= 1;
        end else begin
          m_run <= m_run + 1;
          if (m_run + 1 == LONG_CYC + 1) begin
            m_long <= 1; e_long <= 1; e_hold <= 1;
          end
        end
      end else begin
        if (db_level) begin
          m_press <= 2; e_double <= 1;
        end else begin
          m_run <= m_run + 1;
          if (m_run + 1 == DCLICK_CYC + 1) begin
            m_active <= 0; e_single <= 1; e_busy <= 0;
          end
        end
      end
    end
  end

  // Holds db_level at v for n cycles; called and returns at a negedge.
  task automatic drive(input bit v, input int n);
    db_level = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({single_tick, double_tick, long_tick, long_hold, busy} !== 5'b0) begin
      failed++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {single_tick, double_tick, long_tick, long_hold, busy});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_short_press;
    int s0, d0, l0, f;
    s0 = n_single; d0 = n_double; l0 = n_long;
    drive(1'b1, 5);
    f = cyc;
    drive(1'b0, 20);
    #1;
    tests++;
    if (n_single - s0 != 1 || t_single != f + 11) begin
      failed++;
      $display("FAIL short_single: count %0d at cycle %0d, expected 1 at %0d",
               n_single - s0, t_single, f + 11);
    end
    tests++;
    if (n_double != d0 || n_long != l0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL short_others: double %0d long %0d busy %b, expected 0 0 0",
               n_double - d0, n_long - l0, busy);
    end
  endtask

  task automatic test_long_press;
    int s0, d0, l0, r;
    s0 = n_single; d0 = n_double; l0 = n_long;
    r = cyc;
    drive(1'b1, 40);
    tests++;
    if (long_hold !== 1'b1) begin
      failed++;
      $display("FAIL long_hold_release_cycle: got %b expected 1", long_hold);
    end
    drive(1'b0, 1);
    tests++;
    if (long_hold !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL long_hold_after: hold %b busy %b expected 0 0", long_hold, busy);
    end
    drive(1'b0, 15);
    #1;
    tests++;
    if (n_long - l0 != 1 || t_long != r + 21) begin
      failed++;
      $display("FAIL long_tick: count %0d at cycle %0d, expected 1 at %0d",
               n_long - l0, t_long, r + 21);
    end
    tests++;
    if (n_single != s0 || n_double != d0) begin
      failed++;
      $display("FAIL long_no_click: single %0d double %0d expected 0 0",
               n_single - s0, n_double - d0);
    end
  endtask

  task automatic test_double_click;
    int s0, d0, l0, r2;
    s0 = n_single; d0 = n_double; l0 = n_long;
    drive(1'b1, 5);
    drive(1'b0, 4);
    r2 = cyc;
    drive(1'b1, 30);
    drive(1'b0, 20);
    #1;
    tests++;
    if (n_double - d0 != 1 || t_double != r2 + 1) begin
      failed++;
      $display("FAIL double_tick: count %0d at cycle %0d, expected 1 at %0d",
               n_double - d0, t_double, r2 + 1);
    end
    tests++;
    if (n_single != s0 || n_long != l0) begin
      failed++;
      $display("FAIL double_others: single %0d long %0d expected 0 0",
               n_single - s0, n_long - l0);
    end
  endtask

  task automatic test_boundary;
    int s0, d0, l0, f;
    s0 = n_single; d0 = n_double; l0 = n_long;
    drive(1'b1, LONG_CYC);
    f = cyc;
    drive(1'b0, 20);
    #1;
    tests++;
    if (n_long != l0 || n_single - s0 != 1 || t_single != f + 11) begin
      failed++;
      $display("FAIL boundary_release: long %0d single %0d at %0d, expected 0 1 at %0d",
               n_long - l0, n_single - s0, t_single, f + 11);
    end
    s0 = n_single; d0 = n_double;
    drive(1'b1, 5);
    drive(1'b0, DCLICK_CYC);
    drive(1'b1, 3);
    drive(1'b0, 20);
    #1;
    tests++;
    if (n_double - d0 != 1 || n_single != s0) begin
      failed++;
      $display("FAIL boundary_second_press: double %0d single %0d expected 1 0",
               n_double - d0, n_single - s0);
    end
  endtask

  task automatic test_reset_mid;
    int s0, d0, l0;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(1'b1, 3);
        1: begin drive(1'b1, 3); drive(1'b0, 3); end
        default: drive(1'b1, 25);
      endcase
      tests++;
      if (busy !== 1'b1 || long_hold !== (k == 2)) begin
        failed++;
        $display("FAIL reset_mid_pre%0d: busy %b hold %b expected 1 %b",
                 k, busy, long_hold, k == 2);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      tests++;
      if ({single_tick, double_tick, long_tick, long_hold, busy} !== 5'b0) begin
        failed++;
        $display("FAIL reset_mid%0d: got %b expected 00000", k,
                 {single_tick, double_tick, long_tick, long_hold, busy});
      end
      @(negedge clk);
      db_level = 1'b0;
      reset = 1'b1;
      s0 = n_single; d0 = n_double; l0 = n_long;
      drive(1'b0, 30);
      #1;
      tests++;
      if (n_single != s0 || n_double != d0 || n_long != l0 || busy !== 1'b0) begin
        failed++;
        $display("FAIL reset_mid_after%0d: s %0d d %0d l %0d busy %b expected 0 0 0 0",
                 k, n_single - s0, n_double - d0, n_long - l0, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    int s0, d0, l0, f3;
    s0 = n_single; d0 = n_double; l0 = n_long;
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 3);
    f3 = cyc;
    drive(1'b0, 20);
    #1;
    tests++;
    if (n_double - d0 != 1 || n_single - s0 != 1 || t_single != f3 + 11 || n_long != l0) begin
      failed++;
      $display("FAIL back_to_back: double %0d single %0d at %0d long %0d, expected 1 1 at %0d 0",
               n_double - d0, n_single - s0, t_single, n_long - l0, f3 + 11);
    end
  endtask

  task automatic test_random;
    bit v;
    int len;
    for (int seg = 0; seg < 300; seg++) begin
      v = (seg % 2) == 0;
      case ($urandom_range(0, 3))
        0:       len = v ? $urandom_range(LONG_CYC - 1, LONG_CYC + 1)
                         : $urandom_range(DCLICK_CYC - 1, DCLICK_CYC + 1);
        1:       len = $urandom_range(1, 3);
        2:       len = v ? $urandom_range(1, 30) : $urandom_range(1, 14);
        default: len = $urandom_range(1, 25);
      endcase
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        tests++;
        if ({single_tick, double_tick, long_tick, long_hold, busy} !==
            {e_single, e_double, e_long, e_hold, e_busy}) begin
          failed++;
          $display("FAIL random_model cycle %0d: got s/d/l/h/b %b expected %b", cyc,
                   {single_tick, double_tick, long_tick, long_hold, busy},
                   {e_single, e_double, e_long, e_hold, e_busy});
        end
        tests++;
        if (int'(single_tick) + int'(double_tick) + int'(long_tick) > 1) begin
          failed++;
          $display("FAIL random_onehot cycle %0d: ticks %b expected at most one set", cyc,
                   {single_tick, double_tick, long_tick});
        end
        db_level = v;
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_double_click();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
